// File: rtl/adc_packetizer.sv
// adc_packetizer
// Drains the four per-channel byte buffers (ADC1/2/4/8) in round-robin order.
// Each chunk of PAYLOAD_BYTES is wrapped in an 8-byte header and streamed
// byte-serially to udp_tx_top. Runs entirely in the clk_125m domain.
//
// Optional feature: define ADC_PKT_CHECKSUM_EN to append a 2-byte payload sum
// (mod 2^16, big-endian) after the payload.
//
// Ports:
//   clk          clk_125m
//   rst          synchronous active-high reset
//   en           allows new packets to start; a running packet always completes
//   fifo_ready   per-channel "holds >= PAYLOAD_BYTES" (bit0=ADC1 .. bit3=ADC8)
//   fifo_empty   per-channel buffer empty
//   fifo_dout    byte n on bits [8n+7:8n]; 1-cycle read latency
//   fifo_rd_en   one-hot read strobe
//   udp_tx_busy  transmitter still sending / in its own gap (sampled in IDLE)
//   udp_tx_valid high for the whole packet, contiguous
//   udp_tx_data  packet byte
//   pkt_count    packets completed
//   underflow    sticky: a read was issued to an empty buffer
module adc_packetizer #(
   parameter int          PAYLOAD_BYTES = 1024,
   parameter logic [15:0] MAGIC         = 16'hADC0,
   parameter int          GAP_CYCLES    = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  fifo_ready,
   input  logic [3:0]  fifo_empty,
   input  logic [31:0] fifo_dout,
   output logic [3:0]  fifo_rd_en,
   input  logic        udp_tx_busy,
   output logic        udp_tx_valid,
   output logic [7:0]  udp_tx_data,
   output logic [31:0] pkt_count,
   output logic        underflow
);

   // The shared counter walks header bytes (0..7), payload bytes and gap cycles.
   localparam int CNT_MAX0 = (PAYLOAD_BYTES > GAP_CYCLES) ? PAYLOAD_BYTES : GAP_CYCLES;
   localparam int CNT_MAX  = (CNT_MAX0 > 8) ? CNT_MAX0 : 8;
   localparam int CNT_W    = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(PAYLOAD_BYTES - 1);
   localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(7);

`ifdef ADC_PKT_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE = 3'd0, HEADER = 3'd1, PAYLOAD = 3'd2, CSUM = 3'd3, GAP = 3'd4} state_t;
`else
   typedef enum logic [2:0] {IDLE = 3'd0, HEADER = 3'd1, PAYLOAD = 3'd2, GAP = 3'd4} state_t;
`endif

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       ptr, ch, ch_nxt, pick, cand;
   logic             found, start, pkt_done;
   logic [31:0]      seq;
   logic [7:0]       hdr_q, hdr_nxt, pay_byte;
   logic             sel_fifo, sel_nxt, valid_nxt;
   logic [3:0]       rd_nxt;
`ifdef ADC_PKT_CHECKSUM_EN
   logic [15:0]      sum_q, sum_nxt;
`endif

   // Round-robin search: first ready channel above the last one served.
   always_comb begin
      pick  = ptr;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr + 2'(i);
         if (!found && fifo_ready[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   assign start  = (state == IDLE) && en && !udp_tx_busy && found;
   assign ch_nxt = start ? pick : ch;

   // fifo_dout comes straight from the buffer's output register, so payload
   // bytes are forwarded without a second register stage; this is what lets the
   // first payload byte follow the last header byte with no bubble.
   assign pay_byte    = fifo_dout[8*ch +: 8];
   assign udp_tx_data = sel_fifo ? pay_byte : hdr_q;

`ifdef ADC_PKT_CHECKSUM_EN
   assign sum_nxt  = (state == PAYLOAD) ? sum_q + {8'd0, pay_byte} : sum_q;
   assign pkt_done = (state == CSUM) && (cnt == CNT_W'(1));
`else
   assign pkt_done = (state == PAYLOAD) && (cnt == LAST_PAY);
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = HEADER;
               cnt_nxt   = '0;
            end
         end
         HEADER: begin
            if (cnt == LAST_HDR) begin
               state_nxt = PAYLOAD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         PAYLOAD: begin
            if (cnt == LAST_PAY) begin
`ifdef ADC_PKT_CHECKSUM_EN
               state_nxt = CSUM;
`else
               state_nxt = GAP;
`endif
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`ifdef ADC_PKT_CHECKSUM_EN
         CSUM: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`endif
         GAP: begin
            if (cnt == LAST_GAP) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // FSM output logic: values the output registers take at the next edge,
   // decoded from where the FSM will be in the next cycle.
   always_comb begin
      valid_nxt = 1'b0;
      hdr_nxt   = 8'd0;
      sel_nxt   = 1'b0;
      rd_nxt    = 4'd0;
      case (state_nxt)
         HEADER: begin
            valid_nxt = 1'b1;
            case (cnt_nxt[2:0])
               3'd0: hdr_nxt = MAGIC[15:8];
               3'd1: hdr_nxt = MAGIC[7:0];
               3'd2: hdr_nxt = {6'd0, ch_nxt};
               3'd3: hdr_nxt = {7'd0, underflow};
               3'd4: hdr_nxt = seq[31:24];
               3'd5: hdr_nxt = seq[23:16];
               3'd6: hdr_nxt = seq[15:8];
               default: hdr_nxt = seq[7:0];
            endcase
            // Pre-fetch: the read issued during the last header byte returns
            // the first payload byte.
            if (cnt_nxt == LAST_HDR) rd_nxt = 4'b0001 << ch_nxt;
         end
         PAYLOAD: begin
            valid_nxt = 1'b1;
            sel_nxt   = 1'b1;
            if (cnt_nxt != LAST_PAY) rd_nxt = 4'b0001 << ch_nxt;
         end
`ifdef ADC_PKT_CHECKSUM_EN
         CSUM: begin
            valid_nxt = 1'b1;
            hdr_nxt   = (cnt_nxt == '0) ? sum_nxt[15:8] : sum_nxt[7:0];
         end
`endif
         default: ;
      endcase
   end

   // Output and bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= 2'd3;
         ch           <= 2'd0;
         seq          <= 32'd0;
         pkt_count    <= 32'd0;
         underflow    <= 1'b0;
         udp_tx_valid <= 1'b0;
         hdr_q        <= 8'd0;
         sel_fifo     <= 1'b0;
         fifo_rd_en   <= 4'd0;
      end else begin
         if (start) begin
            ptr <= pick;
            ch  <= pick;
         end
         if (pkt_done) begin
            seq       <= seq + 32'd1;
            pkt_count <= pkt_count + 32'd1;
         end
         if (|(fifo_rd_en & fifo_empty)) underflow <= 1'b1;
         udp_tx_valid <= valid_nxt;
         hdr_q        <= hdr_nxt;
         sel_fifo     <= sel_nxt;
         fifo_rd_en   <= rd_nxt;
      end
   end

`ifdef ADC_PKT_CHECKSUM_EN
   // Payload sum, restarted with every packet
   always_ff @(posedge clk) begin
      if (start) sum_q <= 16'd0;
      else       sum_q <= sum_nxt;
   end
`endif

endmodule

// File: tb/tb_adc_packetizer.sv
// Directed bench for adc_packetizer with PAYLOAD_BYTES=16, GAP_CYCLES=12.
module tb_adc_packetizer;

   localparam int PB = 16;
`ifdef ADC_PKT_CHECKSUM_EN
   localparam int PKT_LEN = 8 + PB + 2;
`else
   localparam int PKT_LEN = 8 + PB;
`endif

   logic        clk = 1'b0;
   logic        rst, en, udp_tx_busy;
   logic [3:0]  fifo_ready, fifo_empty, fifo_rd_en;
   logic [31:0] fifo_dout;
   logic        udp_tx_valid, underflow;
   logic [7:0]  udp_tx_data;
   logic [31:0] pkt_count;

   int total = 0;
   int bad   = 0;

   adc_packetizer #(.PAYLOAD_BYTES(PB), .MAGIC(16'hADC0), .GAP_CYCLES(12)) dut (
      .clk(clk), .rst(rst), .en(en),
      .fifo_ready(fifo_ready), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd_en(fifo_rd_en), .udp_tx_busy(udp_tx_busy),
      .udp_tx_valid(udp_tx_valid), .udp_tx_data(udp_tx_data),
      .pkt_count(pkt_count), .underflow(underflow)
   );

   always #4 clk = ~clk;

   // Buffer model: each channel returns seed, seed+1, ... one cycle after rd_en.
   logic       fifo_load;
   logic [7:0] fifo_seed;
   logic [7:0] ch_byte [4];
   always @(posedge clk) begin
      if (fifo_load) begin
         for (int c = 0; c < 4; c++) ch_byte[c] <= fifo_seed;
      end else begin
         for (int c = 0; c < 4; c++)
            if (fifo_rd_en[c]) begin
               fifo_dout[8*c +: 8] <= ch_byte[c];
               ch_byte[c]          <= ch_byte[c] + 8'd1;
            end
      end
   end

   // Packet capture
   logic [7:0] cur [32];
   int         cur_len = 0, cur_strb = 0, low_cnt = 0, npkt = 0, onehot_bad = 0;
   logic [3:0] cur_mask = 4'd0;
   logic       prev_v = 1'b0;
   logic [7:0] pkt_data [32][32];
   int         pkt_len [32];
   int         pkt_strb [32];
   int         gap_before [32];
   logic [3:0] pkt_mask [32];

   task automatic mon_step();
      if (rst) begin
         cur_len = 0; cur_strb = 0; cur_mask = 4'd0; prev_v = 1'b0; low_cnt = 0;
      end else begin
         if (fifo_rd_en != 4'd0) begin
            cur_strb++;
            cur_mask = cur_mask | fifo_rd_en;
            if (!$onehot(fifo_rd_en)) onehot_bad++;
         end
         if (udp_tx_valid) begin
            if (!prev_v && npkt < 32) gap_before[npkt] = low_cnt;
            if (cur_len < 32) cur[cur_len] = udp_tx_data;
            cur_len++;
         end else begin
            if (prev_v) begin
               if (npkt < 32) begin
                  pkt_len[npkt]  = cur_len;
                  pkt_strb[npkt] = cur_strb;
                  pkt_mask[npkt] = cur_mask;
                  for (int j = 0; j < 32; j++) pkt_data[npkt][j] = cur[j];
               end
               npkt++;
               cur_len = 0; cur_strb = 0; cur_mask = 4'd0; low_cnt = 0;
            end
            low_cnt++;
         end
         prev_v = udp_tx_valid;
      end
   endtask

   initial forever begin
      @(negedge clk);
      mon_step();
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input logic [7:0] seed);
      @(posedge clk); #1;
      rst = 1'b1; fifo_load = 1'b1; fifo_seed = seed;
      en = 1'b0; fifo_ready = 4'd0; fifo_empty = 4'd0; udp_tx_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; fifo_load = 1'b0;
   endtask

   task automatic wait_pkts(input int base, input int n, input int budget);
      int k;
      k = 0;
      while ((npkt - base) < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("npkt", 32'(npkt - base), 32'(n));
   endtask

   task automatic wait_valid(input string tag);
      int k;
      k = 0;
      while (!udp_tx_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(udp_tx_valid), 32'd1);
   endtask

   task automatic chk_pkt(input int idx, input int ech, input int eseq, input int eflags, input int first);
      int errs;
      logic [15:0] sum;
      logic [7:0]  e;
      errs = 0;
      sum  = 16'd0;
      chk("len",   32'(pkt_len[idx]), 32'(PKT_LEN));
      chk("magic", 32'({pkt_data[idx][0], pkt_data[idx][1]}), 32'h0000ADC0);
      chk("chan",  32'(pkt_data[idx][2]), 32'(ech));
      chk("flags", 32'(pkt_data[idx][3]), 32'(eflags));
      chk("seq",   {pkt_data[idx][4], pkt_data[idx][5], pkt_data[idx][6], pkt_data[idx][7]}, 32'(eseq));
      chk("pay0",  32'(pkt_data[idx][8]), 32'(first & 255));
      for (int j = 0; j < PB; j++) begin
         e   = 8'(first + j);
         sum = sum + {8'd0, e};
         if (pkt_data[idx][8+j] !== e) errs++;
      end
      chk("payload", 32'(errs), 32'd0);
      chk("strobes", 32'(pkt_strb[idx]), 32'(PB));
      chk("rdmask",  32'(pkt_mask[idx]), 32'(4'b0001 << ech));
`ifdef ADC_PKT_CHECKSUM_EN
      chk("csum", 32'({pkt_data[idx][8+PB], pkt_data[idx][9+PB]}), 32'(sum));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base, vh;
      rst = 1'b1; en = 1'b0; fifo_ready = 4'd0; fifo_empty = 4'd0;
      udp_tx_busy = 1'b0; fifo_load = 1'b1; fifo_seed = 8'd0;

      // Reset values and ready ordering (ch0 then ch2)
      do_reset(8'h00);
      chk("rst_valid", 32'(udp_tx_valid), 32'd0);
      chk("rst_rd",    32'(fifo_rd_en), 32'd0);
      chk("rst_data",  32'(udp_tx_data), 32'd0);
      chk("rst_cnt",   pkt_count, 32'd0);
      chk("rst_uf",    32'(underflow), 32'd0);
      base = npkt;
      fifo_ready = 4'b0101; en = 1'b1;
      wait_pkts(base, 2, 200);
      chk("pkt_count2", pkt_count, 32'd2);
      chk_pkt(base, 0, 0, 0, 8'h00);
      chk_pkt(base + 1, 2, 1, 0, 8'h00);
      chk("gap", 32'(gap_before[base + 1] >= 12), 32'd1);

      // Full round-robin
      do_reset(8'h00);
      base = npkt;
      fifo_ready = 4'b1111; en = 1'b1;
      wait_pkts(base, 5, 400);
      chk_pkt(base,     0, 0, 0, 8'h00);
      chk_pkt(base + 1, 1, 1, 0, 8'h00);
      chk_pkt(base + 2, 2, 2, 0, 8'h00);
      chk_pkt(base + 3, 3, 3, 0, 8'h00);
      chk_pkt(base + 4, 0, 4, 0, 8'h10);
      chk("onehot", 32'(onehot_bad), 32'd0);

      // Busy gating
      do_reset(8'h5A);
      base = npkt;
      udp_tx_busy = 1'b1; fifo_ready = 4'b0010; en = 1'b1;
      vh = 0;
      repeat (50) begin
         @(negedge clk);
         if (udp_tx_valid) vh++;
      end
      chk("busy_hold", 32'(vh), 32'd0);
      @(posedge clk); #1;
      udp_tx_busy = 1'b0;
      @(negedge clk);
      chk("valid_c0", 32'(udp_tx_valid), 32'd0);
      @(negedge clk);
      chk("valid_c1", 32'(udp_tx_valid), 32'd1);
      wait_pkts(base, 1, 100);
      chk_pkt(base, 1, 0, 0, 8'h5A);

      // Underflow on payload cycle 5
      do_reset(8'h00);
      base = npkt;
      fifo_ready = 4'b0001; en = 1'b1;
      wait_valid("uf_start");
      repeat (13) @(posedge clk);
      #1;
      fifo_empty = 4'b0001;
      chk("uf_pre", 32'(underflow), 32'd0);
      @(posedge clk); #1;
      fifo_empty = 4'b0000;
      chk("uf_set", 32'(underflow), 32'd1);
      wait_pkts(base, 2, 200);
      chk_pkt(base,     0, 0, 0, 8'h00);
      chk_pkt(base + 1, 0, 1, 1, 8'h10);
      chk("uf_sticky", 32'(underflow), 32'd1);

      // Reset at payload byte 3
      do_reset(8'h00);
      fifo_ready = 4'b0001; en = 1'b1;
      wait_valid("mr_start");
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mr_valid", 32'(udp_tx_valid), 32'd0);
      chk("mr_rd",    32'(fifo_rd_en), 32'd0);
      chk("mr_data",  32'(udp_tx_data), 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      base = npkt;
      wait_pkts(base, 1, 100);
      chk_pkt(base, 0, 0, 0, 8'h05);
      chk("mr_count", pkt_count, 32'd1);

      // Payload 0x01..0x10, en dropped mid-packet
      do_reset(8'h01);
      base = npkt;
      fifo_ready = 4'b0001; en = 1'b1;
      wait_valid("en_start");
      en = 1'b0;
      wait_pkts(base, 1, 100);
      chk_pkt(base, 0, 0, 0, 8'h01);
      repeat (100) @(posedge clk);
      #1;
      chk("en_hold", 32'(npkt - base), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_packetizer.md
Name: adc_packetizer

Overview:
- Drains the four per-channel byte buffers (the widthConverter instances for ADC1/2/4/8) in round-robin order.
- Wraps each chunk of PAYLOAD_BYTES in an 8-byte header and streams the result byte-serially into udp_tx_top.
- Sits between the buffers and the UDP transmitter, in the clk_125m domain, and replaces the bare read-controller/address-mux path.

Parameters:
- PAYLOAD_BYTES, 1024, data bytes per packet; must be even and ≥ 2.
- MAGIC, 16'hADC0, header sync word.
- GAP_CYCLES, 12, minimum idle cycles with valid low between packets; minimum 1.

Ports:
- clk  in  1  clk_125m.
- rst  in  1  synchronous, active-high reset.
- en  in  1  permits starting new packets; a packet already in progress always completes.
- fifo_ready  in  4  per-channel flag: the buffer holds ≥ PAYLOAD_BYTES. Bit0=ADC1, bit1=ADC2, bit2=ADC4, bit3=ADC8.
- fifo_empty  in  4  per-channel buffer empty.
- fifo_dout  in  32  byte n = bits [8n+7:8n], one byte per channel; standard FIFO with 1-cycle read latency.
- fifo_rd_en  out  4  one-hot read strobe.
- udp_tx_busy  in  1  high while the transmitter is still sending or in its own gap.
- udp_tx_valid  out  1  high for the whole packet, contiguous; the falling edge ends the packet.
- udp_tx_data  out  8  packet byte.
- pkt_count  out  32  packets completed.
- underflow  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values: fifo_rd_en=0, udp_tx_valid=0, udp_tx_data=0, pkt_count=0, underflow=0. Sequence counter=0. Round-robin pointer=3, so the first channel served is ch0.
- Reset mid-packet: all outputs take their reset values at the next edge. No trailing bytes are sent.
- All outputs are registered.
- FSM states: IDLE, HEADER, PAYLOAD, CSUM (optional feature only), GAP.
- IDLE:
  - Condition to start: en=1, udp_tx_busy=0 and any fifo_ready bit set.
  - Channel choice: the first ready channel searching upward from pointer+1, mod 4.
  - On start: latch the channel, set pointer to that channel, go to HEADER.
  - udp_tx_valid rises on the next cycle, i.e. 1 cycle latency from the decision.
- HEADER: 8 cycles with valid high. Bytes in order:
  - MAGIC[15:8], MAGIC[7:0].
  - channel id (0..3).
  - flags: bit0 = underflow, bits[7:1] = 0.
  - seq[31:24], seq[23:16], seq[15:8], seq[7:0].
- Read pre-fetch: fifo_rd_en[ch] is asserted in the cycle after the 7th header byte is presented. Its first returned byte therefore appears on udp_tx_data in the first PAYLOAD cycle, with no bubble.
- PAYLOAD:
  - Exactly PAYLOAD_BYTES cycles, one byte per cycle from fifo_dout byte [ch], valid held high.
  - fifo_rd_en[ch] is asserted for exactly PAYLOAD_BYTES consecutive cycles, leading the data by 1 cycle.
- Underflow: if fifo_empty[ch]=1 in a cycle where fifo_rd_en[ch] is driven, set underflow. The transfer continues and the byte sent is whatever fifo_dout holds; the packet length never changes.
- Packet end:
  - udp_tx_valid drops after the last byte.
  - The sequence counter and pkt_count both increment, wrapping at 2^32.
  - Go to GAP.
- GAP: valid low for GAP_CYCLES, then IDLE.
- fifo_ready changes during a packet do not affect the channel in service.
- en falling mid-packet has no effect; the packet completes. No new packet starts until en returns high.
- udp_tx_busy is sampled only in IDLE.
- Never more than one fifo_rd_en bit is high at a time.

Optional Feature:
- Macro: ADC_PKT_CHECKSUM_EN.
- When defined:
  - The CSUM state follows PAYLOAD: 2 extra valid-high cycles sending sum[15:8] then sum[7:0].
  - sum = unsigned sum of all payload bytes mod 2^16, cleared at each packet start.
  - Packet length is 8 + PAYLOAD_BYTES + 2.
- When undefined: no CSUM state, packet length is 8 + PAYLOAD_BYTES, and no summing logic exists.

Test Plan:
- Ready ordering: reset, then en=1, fifo_ready=4'b0101, payload bytes 0x00..0xFF repeating, PAYLOAD_BYTES=16. Expect a ch0 packet, then a ch2 packet:
  - ch0 header AD C0 00 00 00 00 00 00;
  - ch2 seq=1;
  - each packet 24 contiguous valid cycles;
  - ≥12 low cycles between packets;
  - pkt_count=2.
- Full round-robin: all 4 channels ready continuously. Expect the channel-id sequence 0,1,2,3,0, with fifo_rd_en one-hot and exactly 16 strobes per packet.
- Busy gating: udp_tx_busy held high for 50 cycles with ch1 ready. Expect udp_tx_valid=0 until 1 cycle after busy falls; the first data byte equals the first FIFO word, with no bubble after the header.
- Underflow: fifo_empty[0] forced high for payload cycle 5. Expect underflow=1 sticky, the packet still 24 bytes, and the next packet's flags byte = 0x01.
- Reset mid-packet: rst asserted at payload byte 3. Expect udp_tx_valid=0 and fifo_rd_en=0 at the next edge. After release, the next packet has seq=0 on ch0.
- Checksum: with ADC_PKT_CHECKSUM_EN defined and payload 0x01..0x10, expect trailer bytes 00 88 and packet length 26.
